// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one ARM data-processing op at a time to an external
// ALU. It walks IDLE -> SETUP -> EXEC -> WB, computes NZCV from the ALU result
// and holds the writeback until it is accepted.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  opcode,
  input  logic        set_flags,
  input  logic [3:0]  rd,
  input  logic [31:0] rn_data,
  input  logic [31:0] op2_data,
  output logic        alu_enable,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_operand1,
  output logic [31:0] alu_operand2,
  output logic        alu_in_carry,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_negative,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        illegal_op,
  output logic [3:0]  flags_nzcv
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EXEC, S_WB} state_t;
  // How C and V are derived when flags are written.
  typedef enum logic [1:0] {FK_LOGIC, FK_ADD, FK_SUB} flag_kind_t;

  localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010,
                         OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_TST = 4'b1000,
                         OP_CMP = 4'b1010, OP_ORR = 4'b1100;

  state_t     state, next_state;
  flag_kind_t flag_kind, dec_kind;
  logic       flag_upd;
  logic       dec_legal, dec_we, dec_force;
  logic [3:0] dec_ctrl;
  logic       accept;
  logic       v_add, v_sub;

  assign instr_ready = (state == S_IDLE);
  assign wb_valid    = (state == S_WB);
  assign accept      = instr_valid && instr_ready;

  // Opcode decode: ALU control code, writeback enable and flag behaviour.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    dec_legal = 1'b1;
    dec_we    = 1'b1;
    dec_force = 1'b0;
    dec_ctrl  = 4'd0;
    dec_kind  = FK_LOGIC;
    unique case (opcode)
      OP_AND: dec_ctrl = 4'd2;
      OP_EOR: dec_ctrl = 4'd7;
      OP_SUB: begin dec_ctrl = 4'd1; dec_kind = FK_SUB; end
      OP_ADD: begin dec_ctrl = 4'd4; dec_kind = FK_ADD; end
      OP_ADC: begin dec_ctrl = 4'd5; dec_kind = FK_ADD; end
      OP_TST: begin dec_ctrl = 4'd2; dec_we = 1'b0; dec_force = 1'b1; end
      OP_CMP: begin
        dec_ctrl  = 4'd1;
        dec_kind  = FK_SUB;
        dec_we    = 1'b0;
        dec_force = 1'b1;
      end
      OP_ORR: dec_ctrl = 4'd3;
      default: begin dec_legal = 1'b0; dec_we = 1'b0; end
    endcase
  end

  // Signed overflow from operand and result sign bits; Z is derived locally too.
  always_comb begin
    v_add = (alu_operand1[31] == alu_operand2[31]) && (alu_result[31] != alu_operand1[31]);
    v_sub = (alu_operand1[31] != alu_operand2[31]) && (alu_result[31] != alu_operand1[31]);
  end

  // Next-state logic; illegal ops skip the ALU and go straight to writeback.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (instr_valid) next_state = dec_legal ? S_SETUP : S_WB;
      S_SETUP: next_state = S_EXEC;
      S_EXEC:  next_state = S_WB;
      S_WB:    if (wb_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Datapath: capture on accept, pulse enable in EXEC, sample result and flags leaving EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_enable   <= 1'b0;
      alu_control  <= 4'd0;
      alu_operand1 <= 32'd0;
      alu_operand2 <= 32'd0;
      alu_in_carry <= 1'b0;
      wb_rd        <= 4'd0;
      wb_data      <= 32'd0;
      wb_we        <= 1'b0;
      illegal_op   <= 1'b0;
      flags_nzcv   <= 4'd0;
      flag_kind    <= FK_LOGIC;
      flag_upd     <= 1'b0;
    end else begin
      alu_enable <= (state == S_SETUP);
      if (accept) begin
        wb_rd      <= rd;
        wb_data    <= 32'd0;
        wb_we      <= dec_we;
        illegal_op <= !dec_legal;
        if (dec_legal) begin
          alu_control  <= dec_ctrl;
          alu_operand1 <= rn_data;
          alu_operand2 <= op2_data;
          alu_in_carry <= (opcode == OP_ADC) ? flags_nzcv[1] : 1'b0;
          flag_kind    <= dec_kind;
          flag_upd     <= set_flags || dec_force;
        end
      end
      if (state == S_EXEC) begin
        wb_data <= alu_result;
        if (flag_upd) begin
          flags_nzcv[3] <= alu_result[31];
          flags_nzcv[2] <= (alu_result == 32'd0);
          unique case (flag_kind)
            FK_ADD: begin flags_nzcv[1] <= alu_overflow;  flags_nzcv[0] <= v_add; end
            FK_SUB: begin flags_nzcv[1] <= ~alu_negative; flags_nzcv[0] <= v_sub; end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
